// File: rtl/mem_streams_reader.sv
// Replays the frame stored in a multi-channel stream RAM NUM_PASSES times, with sideband aligned to READ_LATENCY.
// Optional build macro MEM_STREAMS_READER_OVR_CNT_EN enables the dropped-frame counter o_ovr_cnt.
module mem_streams_reader #(
   parameter int CHANNELS     = 16,
   parameter int RDATA_WIDTH  = 64,
   parameter int RADDR_WIDTH  = 11,
   parameter int READ_LATENCY = 3,
   parameter int NUM_PASSES   = 4
) (
   input  logic                            i_clk,
   input  logic                            i_reset_n,
   input  logic                            i_rvalid,
   input  logic                            i_wr_wen,
   input  logic                            i_hold,
   input  logic [CHANNELS*RDATA_WIDTH-1:0] i_rd_data,
   output logic                            o_rd_ren,
   output logic [RADDR_WIDTH-1:0]          o_rd_addr,
   output logic [CHANNELS*RDATA_WIDTH-1:0] o_tdata,
   output logic                            o_tvalid,
   output logic                            o_tsop,
   output logic                            o_tlast,
   output logic [3:0]                      o_pass_idx,
   output logic                            o_busy,
   output logic                            o_overrun,
   output logic [15:0]                     o_ovr_cnt
);
   localparam int LW = RADDR_WIDTH + 1;
   localparam logic [LW-1:0] LEN_ONE    = {{RADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [LW-1:0] LEN_MAX    = {1'b1, {RADDR_WIDTH{1'b0}}};
   localparam logic [3:0]    PASS_LAST  = 4'(NUM_PASSES - 1);
   localparam logic [3:0]    DRAIN_LAST = 4'(READ_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_rvalid_d;
   logic                   r_armed;
   logic [LW-1:0]          r_len_cnt;
   logic [LW-1:0]          r_len_q;
   logic [RADDR_WIDTH-1:0] r_addr;
   logic [RADDR_WIDTH-1:0] r_last_addr;
   logic [3:0]             r_pass;
   logic [3:0]             r_drain_cnt;
   logic                   r_overrun;

   logic w_rise, w_fall, w_accept, w_drop, w_ren, w_addr_last, w_pass_last, w_end, w_drain_done;

   assign w_rise       = i_rvalid & ~r_rvalid_d;
   assign w_fall       = r_armed & r_rvalid_d & ~i_rvalid;
   assign w_accept     = w_fall & (r_state == S_IDLE);
   assign w_drop       = w_fall & (r_state != S_IDLE);
   assign w_ren        = (r_state == S_READ) & ~i_hold;
   assign w_addr_last  = ({1'b0, r_addr} == (r_len_q - LEN_ONE));
   assign w_pass_last  = (r_pass == PASS_LAST);
   assign w_end        = w_ren & w_addr_last & w_pass_last;
   assign w_drain_done = (r_drain_cnt == DRAIN_LAST);

   // Reset r_rvalid_d to 1 so a frame window already open at release never arms the reader.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rvalid_d <= 1'b1;
         r_armed    <= 1'b0;
         r_len_cnt  <= '0;
         r_len_q    <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_rvalid_d <= i_rvalid;
         r_overrun  <= w_drop;
         if (w_rise) r_armed <= 1'b1;
         if (w_rise) r_len_cnt <= i_wr_wen ? LEN_ONE : '0;
         else if (i_rvalid && i_wr_wen && (r_len_cnt != LEN_MAX)) r_len_cnt <= r_len_cnt + LEN_ONE;
         if (w_accept) r_len_q <= r_len_cnt;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && (r_len_cnt != '0)) w_state_nxt = S_READ;
         S_READ:  if (w_end) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_rd_ren  = w_ren;
      o_rd_addr = w_ren ? r_addr : r_last_addr;
      o_busy    = (r_state != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_addr      <= '0;
         r_last_addr <= '0;
         r_pass      <= '0;
         r_drain_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= '0;
            r_pass <= '0;
         end else if (w_ren) begin
            r_last_addr <= r_addr;
            if (w_addr_last) begin
               r_addr <= '0;
               if (!w_pass_last) r_pass <= r_pass + 4'd1;
            end else begin
               r_addr <= r_addr + 1'b1;
            end
         end
         r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 4'd1 : 4'd0;
      end
   end

   // Sideband travels with each issued read so it lines up with the RAM word READ_LATENCY cycles later.
   logic       r_dl_vld  [READ_LATENCY];
   logic       r_dl_sop  [READ_LATENCY];
   logic       r_dl_last [READ_LATENCY];
   logic [3:0] r_dl_pass [READ_LATENCY];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_dl_vld[i]  <= 1'b0;
            r_dl_sop[i]  <= 1'b0;
            r_dl_last[i] <= 1'b0;
            r_dl_pass[i] <= 4'd0;
         end
      end else begin
         r_dl_vld[0]  <= w_ren;
         r_dl_sop[0]  <= w_ren & (r_addr == '0);
         r_dl_last[0] <= w_ren & w_addr_last;
         r_dl_pass[0] <= w_ren ? r_pass : 4'd0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_dl_vld[i]  <= r_dl_vld[i-1];
            r_dl_sop[i]  <= r_dl_sop[i-1];
            r_dl_last[i] <= r_dl_last[i-1];
            r_dl_pass[i] <= r_dl_pass[i-1];
         end
      end
   end

   assign o_tdata    = i_rd_data;
   assign o_tvalid   = r_dl_vld[READ_LATENCY-1];
   assign o_tsop     = r_dl_sop[READ_LATENCY-1];
   assign o_tlast    = r_dl_last[READ_LATENCY-1];
   assign o_pass_idx = r_dl_pass[READ_LATENCY-1];
   assign o_overrun  = r_overrun;

`ifdef MEM_STREAMS_READER_OVR_CNT_EN
   logic [15:0] r_ovr_cnt;
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_ovr_cnt <= 16'd0;
      else if (r_overrun && (r_ovr_cnt != 16'hFFFF)) r_ovr_cnt <= r_ovr_cnt + 16'd1;
   end
   assign o_ovr_cnt = r_ovr_cnt;
`else
   assign o_ovr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mem_streams_reader.sv
// Bench for mem_streams_reader: randomized frames and holds against a frame/pass-level model with a latency-L RAM model.
module tb_mem_streams_reader;
   localparam int CH = 16, RW = 64, AW = 11, L = 3, P = 4;
   localparam int DW = CH * RW;
`ifdef MEM_STREAMS_READER_OVR_CNT_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic i_clk = 1'b0, i_reset_n = 1'b0, i_rvalid = 1'b0, i_wr_wen = 1'b0, i_hold = 1'b0;
   logic [DW-1:0] i_rd_data;
   logic          o_rd_ren, o_tvalid, o_tsop, o_tlast, o_busy, o_overrun;
   logic [AW-1:0] o_rd_addr;
   logic [DW-1:0] o_tdata;
   logic [3:0]    o_pass_idx;
   logic [15:0]   o_ovr_cnt;

   mem_streams_reader #(.CHANNELS(CH), .RDATA_WIDTH(RW), .RADDR_WIDTH(AW),
                        .READ_LATENCY(L), .NUM_PASSES(P)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rvalid(i_rvalid), .i_wr_wen(i_wr_wen),
      .i_hold(i_hold), .i_rd_data(i_rd_data), .o_rd_ren(o_rd_ren), .o_rd_addr(o_rd_addr),
      .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tsop(o_tsop), .o_tlast(o_tlast),
      .o_pass_idx(o_pass_idx), .o_busy(o_busy), .o_overrun(o_overrun), .o_ovr_cnt(o_ovr_cnt));

   always #5 i_clk = ~i_clk;

   typedef struct {int addr; int pass; bit sop; bit last;} word_t;
   word_t exp_out[$];
   int    exp_rd[$];
   int    ren_cyc[$];
   int    n_vec = 0, n_err = 0, cyc_n = 0;
   int    n_ren = 0, n_tv = 0, ovr_seen = 0, last_ren = 0, last_addr = 0, acc_cyc = 0;
   bit    prev_busy = 1'b0;

   logic [RW-1:0] mem [2**AW];
   logic [AW:0]   rp  [L];

   function automatic logic [DW-1:0] ram_word(input int a);
      logic [DW-1:0] w;
      for (int c = 0; c < CH; c++) w[c*RW +: RW] = mem[a] + RW'(c);
      return w;
   endfunction

   // External RAM: word for an address read at cycle t appears on i_rd_data at cycle t+L.
   always @(posedge i_clk) begin
      rp[0] <= {o_rd_ren, o_rd_addr};
      for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
   end
   always_comb i_rd_data = ram_word(int'(rp[L-1][AW-1:0]));

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      word_t e;
      if (i_hold) chk("hold_ren", DW'(o_rd_ren), DW'(0));
      if (o_rd_ren) begin
         n_ren++;
         if (exp_rd.size() == 0) chk("extra_ren", DW'(1), DW'(0));
         else chk("rd_addr", DW'(o_rd_addr), DW'(exp_rd.pop_front()));
         ren_cyc.push_back(cyc_n);
         last_ren  = cyc_n;
         last_addr = int'(o_rd_addr);
      end else if (i_hold && o_busy && exp_rd.size() > 0) begin
         chk("addr_hold", DW'(o_rd_addr), DW'(last_addr));
      end
      if (o_tvalid) begin
         n_tv++;
         if (exp_out.size() == 0) chk("extra_tvalid", DW'(1), DW'(0));
         else begin
            e = exp_out.pop_front();
            chk("tdata", o_tdata, ram_word(e.addr));
            chk("tsop", DW'(o_tsop), DW'(e.sop));
            chk("tlast", DW'(o_tlast), DW'(e.last));
            chk("pass_idx", DW'(o_pass_idx), DW'(e.pass));
            if (ren_cyc.size() > 0) chk("latency", DW'(cyc_n - ren_cyc.pop_front()), DW'(L));
         end
      end
      if (o_overrun) ovr_seen++;
      // Last read issued at T: L drain cycles follow, busy first low at T+L+1.
      if (prev_busy && !o_busy) chk("busy_fall", DW'(cyc_n), DW'(last_ren + L + 1));
      prev_busy = o_busy;
   endtask

   task automatic cyc();
      #2;
      monitor();
      @(posedge i_clk);
      cyc_n++;
      @(negedge i_clk);
   endtask

   task automatic push_frame(input int n);
      for (int p = 0; p < P; p++)
         for (int a = 0; a < n; a++) begin
            exp_rd.push_back(a);
            exp_out.push_back('{a, p, a == 0, a == n - 1});
         end
   endtask

   task automatic send_frame(input int hi, input int nw, input bit accept);
      int left = nw;
      for (int c = 0; c < hi; c++) begin
         i_rvalid = 1'b1;
         i_wr_wen = (left == hi - c) || (left > 0 && $urandom_range(1) == 1);
         if (i_wr_wen) left--;
         cyc();
      end
      i_rvalid = 1'b0;
      i_wr_wen = 1'b0;
      acc_cyc  = cyc_n;
      if (accept && nw > 0) push_frame(nw > 2**AW ? 2**AW : nw);
      cyc();
   endtask

   task automatic wait_idle(input int hold_pct);
      int budget = 5000;
      while ((o_busy || exp_out.size() > 0) && budget > 0) begin
         i_hold = ($urandom_range(99) < hold_pct);
         cyc();
         budget--;
      end
      i_hold = 1'b0;
      if (budget == 0) chk("timeout", DW'(1), DW'(0));
      chk("left_words", DW'(exp_out.size() + exp_rd.size()), DW'(0));
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic run_until_rd_left(input int left);
      int budget = 500;
      while (exp_rd.size() > left && budget > 0) begin cyc(); budget--; end
      if (budget == 0) chk("wait_rd", DW'(exp_rd.size()), DW'(left));
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_ren"}, DW'(o_rd_ren), DW'(0));
      chk({tag, "_addr"}, DW'(o_rd_addr), DW'(0));
      chk({tag, "_tvalid"}, DW'({o_tvalid, o_tsop, o_tlast}), DW'(0));
      chk({tag, "_pass"}, DW'(o_pass_idx), DW'(0));
      chk({tag, "_busy"}, DW'(o_busy), DW'(0));
      chk({tag, "_ovr"}, DW'({o_overrun, o_ovr_cnt}), DW'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2**AW; i++) mem[i] = {$urandom, $urandom};
      for (int i = 0; i < L; i++) rp[i] = '0;
      i_rvalid = 1'b1;
      i_wr_wen = 1'b1;
      @(negedge i_clk);
      idle(2);
      chk_zero_outputs("reset");

      // Window already open at release: its falling edge must not start a read.
      i_reset_n = 1'b1;
      idle(3);
      i_rvalid = 1'b0;
      i_wr_wen = 1'b0;
      idle(6);
      chk("unarmed_busy", DW'(o_busy), DW'(0));
      chk("unarmed_ren", DW'(n_ren), DW'(0));

      n_ren = 0; n_tv = 0;
      send_frame(10, 8, 1'b1);
      wait_idle(0);
      chk("basic_ren_cnt", DW'(n_ren), DW'(32));
      chk("basic_tv_cnt", DW'(n_tv), DW'(32));
      idle(3);

      n_ren = 0; n_tv = 0;
      send_frame(10, 8, 1'b1);
      run_until_rd_left(22);
      i_hold = 1'b1;
      idle(5);
      i_hold = 1'b0;
      wait_idle(0);
      chk("hold_ren_cnt", DW'(n_ren), DW'(32));
      chk("hold_tv_cnt", DW'(n_tv), DW'(32));
      idle(2);

      n_ren = 0;
      send_frame(6, 0, 1'b1);
      idle(8);
      chk("zero_len_busy", DW'(o_busy), DW'(0));
      chk("zero_len_ren", DW'(n_ren), DW'(0));

      n_tv = 0;
      send_frame(3, 1, 1'b1);
      wait_idle(0);
      chk("len1_tv_cnt", DW'(n_tv), DW'(P));
      idle(2);

      repeat (8) begin
         int n;
         n = $urandom_range(1, 20);
         n_tv = 0;
         send_frame(n + $urandom_range(0, 4), n, 1'b1);
         wait_idle(25);
         chk("rand_tv_cnt", DW'(n_tv), DW'(n * P));
         idle($urandom_range(1, 4));
      end

      ovr_seen = 0;
      n_tv = 0;
      send_frame(10, 8, 1'b1);
      send_frame(5, 4, 1'b0);
      wait_idle(0);
      chk("ovr_pulses", DW'(ovr_seen), DW'(1));
      chk("ovr_first_tv", DW'(n_tv), DW'(32));
      idle(2);
      chk("ovr_cnt1", DW'(o_ovr_cnt), DW'(OVR_EN ? 1 : 0));

      // Second frame's falling edge lands on the cycle the reader leaves DRAIN: dropped.
      send_frame(4, 4, 1'b1);
      begin
         int f;
         f = acc_cyc + 4 * P + L;
         while (cyc_n < f - 3) cyc();
         i_rvalid = 1'b1;
         i_wr_wen = 1'b1;
         while (cyc_n < f) cyc();
         i_rvalid = 1'b0;
         i_wr_wen = 1'b0;
         cyc();
      end
      wait_idle(0);
      idle(6);
      chk("edge_drop_pulses", DW'(ovr_seen), DW'(2));
      chk("edge_drop_busy", DW'(o_busy), DW'(0));
      chk("ovr_cnt2", DW'(o_ovr_cnt), DW'(OVR_EN ? 2 : 0));

      send_frame(10, 8, 1'b1);
      run_until_rd_left(13);
      #1;
      i_reset_n = 1'b0;
      #1;
      chk_zero_outputs("midrst");
      exp_rd.delete();
      exp_out.delete();
      ren_cyc.delete();
      prev_busy = 1'b0;
      last_addr = 0;
      @(negedge i_clk);
      idle(2);
      i_reset_n = 1'b1;
      n_tv = 0;
      idle(8);
      chk("post_rst_tv", DW'(n_tv), DW'(0));
      send_frame(5, 3, 1'b1);
      wait_idle(0);
      chk("post_rst_words", DW'(n_tv), DW'(12));
      chk("post_rst_ovr_cnt", DW'(o_ovr_cnt), DW'(0));
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
